inst_fetch: RTL and testbench

- Instruction-fetch initiator for the byte-addressed instruction ROM; owns the fetch PC and drives the ROM address/enable.
- Captures the 32-bit word the ROM returns combinationally in the same cycle into a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake; handles branch/jump redirects and out-of-range fetches.

---
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode handshake: the fetch unit is the master and presents one
// instruction per beat. The decoder is the slave and accepts it with out_ready.
interface inst_fetch_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;

    modport master (
        output out_valid,
        output out_inst,
        output out_pc,
        output out_fault,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  out_fault,
        output out_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit. It owns the fetch PC, reads the combinational ROM,
// and buffers the words in a small circular prefetch queue for decode.
// Optional feature macro: IF_MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect target becomes a single fault entry instead of being silently aligned.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 4096,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        rom_addr,
    output logic               rom_en,
    input  logic [31:0]        rom_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    inst_fetch_if.master       dec
);
    localparam int unsigned PtrW     = $clog2(QDEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam logic [31:0] LastAddr = 32'(ROM_BYTES - 4);
    localparam logic [31:0] Nop      = 32'h0000_0013;

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              boot_q;
    logic [PtrW-1:0]   head_q, tail_q;
    logic [CntW-1:0]   count_q;
    logic [31:0]       inst_mem  [QDEPTH];
    logic [31:0]       pc_mem    [QDEPTH];
    logic              fault_mem [QDEPTH];

    logic              pop;
    logic              space;
    logic              push;
    logic              push_fault;
    logic              bad_addr;
    logic              not_empty;

    assign not_empty     = (count_q != '0) && !rst;
    assign dec.out_valid = not_empty;
    assign dec.out_inst  = not_empty ? inst_mem[head_q]  : Nop;
    assign dec.out_pc    = not_empty ? pc_mem[head_q]    : 32'h0;
    assign dec.out_fault = not_empty ? fault_mem[head_q] : 1'b0;
    assign rom_addr      = fetch_pc_q;

    // Handshake decode, range check, next PC and next state.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rom_en     = 1'b0;
        push       = 1'b0;
        push_fault = 1'b0;
        // A redirect cancels any acceptance in the same cycle.
        pop        = not_empty && dec.out_ready && !redirect_valid;
        space      = (count_q < CntW'(QDEPTH)) || (not_empty && dec.out_ready);
`ifdef IF_MISALIGN_TRAP_EN
        bad_addr   = (fetch_pc_q > LastAddr) || (fetch_pc_q[1:0] != 2'b00);
`else
        bad_addr   = (fetch_pc_q > LastAddr);
`endif
        if (redirect_valid) begin
            state_d = StRun;
`ifdef IF_MISALIGN_TRAP_EN
            fetch_pc_d = redirect_pc;
`else
            fetch_pc_d = redirect_pc & ~32'h3;
`endif
        end else if (state_q == StRun && !boot_q && space) begin
            if (bad_addr) begin
                push       = 1'b1;
                push_fault = 1'b1;
                state_d    = StFault;
            end else begin
                rom_en     = 1'b1;
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
        if (rst) begin
            rom_en = 1'b0;
            push   = 1'b0;
            pop    = 1'b0;
        end
    end

    // FSM state, fetch PC and the post-reset idle cycle.
    always_ff @(posedge clk) begin
        boot_q <= rst;
        if (rst) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Queue pointers and occupancy; flushed by reset or redirect.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PtrW'(1);
            if (pop)  head_q <= head_q + PtrW'(1);
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Queue storage; only written on a push, so the head is stable while stalled.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q]  <= push_fault ? Nop : rom_data;
            pc_mem[tail_q]    <= fetch_pc_q;
            fault_mem[tail_q] <= push_fault;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// ready/redirect/reset traffic, compared each cycle against a queue-based model.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned ROM_BYTES = 4096;
    localparam int unsigned QDEPTH    = 2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic        rom_en;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    inst_fetch_if dec_if ();

    inst_fetch #(
        .RESET_PC  (RESET_PC),
        .ROM_BYTES (ROM_BYTES),
        .QDEPTH    (QDEPTH)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_en         (rom_en),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec_if.master)
    );

    always #5 clk = ~clk;

    // Distinct word per address: multiplication by an odd constant is a bijection.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    bit          m_fault;
    bit          m_boot;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit bad_target(input logic [31:0] a);
`ifdef IF_MISALIGN_TRAP_EN
        return (a > ROM_BYTES - 4) || (a[1:0] != 2'b00);
`else
        return (a > ROM_BYTES - 4);
`endif
    endfunction

    // Compare this cycle's outputs with the model, then advance the model one edge.
    task automatic model_cycle();
        bit     exp_valid, exp_en, space, take;
        entry_t e;
        exp_valid = !rst && mq.size() > 0;
        take      = exp_valid && dec_if.out_ready;
        space     = mq.size() < QDEPTH || take;
        exp_en    = !rst && !redirect_valid && !m_boot && !m_fault && space && !bad_target(m_pc);

        check("rom_en", 32'(rom_en), 32'(exp_en));
        if (exp_en) check("rom_addr", rom_addr, m_pc);
        check("out_valid", 32'(dec_if.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_inst", dec_if.out_inst, mq[0].inst);
            check("out_pc", dec_if.out_pc, mq[0].pc);
            check("out_fault", 32'(dec_if.out_fault), 32'(mq[0].fault));
        end else if (rst || m_boot) begin
            check("idle_inst", dec_if.out_inst, NOP);
            check("idle_pc", dec_if.out_pc, 32'h0);
            check("idle_fault", 32'(dec_if.out_fault), 32'h0);
        end

        if (rst) begin
            mq.delete();
            m_pc = RESET_PC; m_fault = 0; m_boot = 1;
        end else if (redirect_valid) begin
            mq.delete();
`ifdef IF_MISALIGN_TRAP_EN
            m_pc = redirect_pc;
`else
            m_pc = {redirect_pc[31:2], 2'b00};
`endif
            m_fault = 0; m_boot = 0;
        end else begin
            if (take) void'(mq.pop_front());
            if (!m_boot && !m_fault && space) begin
                if (bad_target(m_pc)) begin
                    e.inst = NOP; e.pc = m_pc; e.fault = 1'b1;
                    mq.push_back(e);
                    m_fault = 1;
                end else begin
                    e.inst = rom_word(m_pc); e.pc = m_pc; e.fault = 1'b0;
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_boot = 0;
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        rst = r; redirect_valid = rv; redirect_pc = rp; dec_if.out_ready = rdy;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] tgt;
        dec_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        // Straight-line fetch from RESET_PC.
        run(7, 1'b1);
        // Backpressure: queue fills, fetch stalls, then resumes in order.
        run(5, 1'b0);
        run(4, 1'b1);
        // Redirect with a full queue while decode is ready.
        run(3, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        run(5, 1'b1);
        // Run off the end of the ROM.
        step(1'b0, 1'b1, 32'hFF8, 1'b1);
        run(8, 1'b1);
        // Misaligned redirect target.
        step(1'b0, 1'b1, 32'h102, 1'b1);
        run(6, 1'b1);
        // Reset mid-stream with a full queue.
        run(3, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        run(5, 1'b1);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 4)
                0: tgt = ($urandom % (ROM_BYTES / 4)) * 4;
                1: tgt = ROM_BYTES - 8 + 4 * ($urandom % 3);
                2: tgt = $urandom % ROM_BYTES;
                default: tgt = 32'hFFFF_FFF8 + ($urandom % 8);
            endcase
            step(($urandom % 200) == 0, ($urandom % 20) == 0, tgt, ($urandom % 4) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
